// File: rtl/rng_pkg.sv
// rng_pkg: shared LFSR constants, per-channel salt/zero-guard helpers and FSM encoding.
// Latency: n/a (package only).
// Backpressure: n/a.
// Ports: none.
package rng_pkg;

  localparam int LFSR_W = 32;
  // x^32 + x^22 + x^2 + x + 1 in right-shifting Galois form
  localparam logic [LFSR_W-1:0] TAP_MASK = 32'h8020_0003;

  typedef enum logic [1:0] {
    WARMUP = 2'd0,
    LOAD   = 2'd1,
    RUN    = 2'd2
  } fsm_e;

  // Odd channels get the complemented seed; each channel pair is spread by the
  // golden-ratio constant so neighbouring pairs start far apart.
  function automatic logic [LFSR_W-1:0] salt(input int i);
    logic [LFSR_W-1:0] iv;
    logic [LFSR_W-1:0] odd_mask;
    logic [LFSR_W-1:0] pair;
    iv       = i;
    odd_mask = {LFSR_W{iv[0]}};
    pair     = (iv >> 1) * 32'h9E37_79B9;
    return odd_mask ^ pair;
  endfunction

  // The all-zero state is a fixed point of the LFSR, so it is never loaded.
  function automatic logic [LFSR_W-1:0] guard(input logic [LFSR_W-1:0] s);
    return (s == '0) ? 32'h0000_0001 : s;
  endfunction

endpackage

// File: rtl/lfsr_leap_core.sv
// lfsr_leap_core: one 32-bit Galois LFSR that jumps LEAP shifts per advance.
// Latency: load/advance visible on state one cycle after the request.
// Backpressure: none; state holds whenever neither load nor adv is asserted.
// Ports: clk, reset (async active-low), load + load_val (priority), adv, state (current value).
module lfsr_leap_core
  import rng_pkg::*;
#(
  parameter int                LEAP      = 1,
  parameter logic [LFSR_W-1:0] RESET_VAL = 32'h0000_0001
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [LFSR_W-1:0] load_val,
  input  logic              adv,
  output logic [LFSR_W-1:0] state
);

  logic [LFSR_W-1:0] state_q;
  logic [LFSR_W-1:0] state_d;
  logic [LFSR_W-1:0] leap_val;

  always_comb begin
    // LEAP single shifts chained combinationally so one advance costs one cycle
    leap_val = state_q;
    for (int k = 0; k < LEAP; k++) begin
      leap_val = (leap_val >> 1) ^ (leap_val[0] ? TAP_MASK : '0);
    end
    state_d = state_q;
    if (load) begin
      state_d = load_val;
    end else if (adv) begin
      state_d = leap_val;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RESET_VAL;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/rng_bank.sv
// rng_bank: NUM_CH salted 32-bit LFSRs with post-(re)seed warm-up, one OUT_W-bit word per channel per transfer.
// Latency: first rnd_valid WARMUP_CYC+1 edges after reset release or after the edge sampling seed_load.
// Backpressure: valid/ready; rnd and LFSR states hold while rnd_valid=1 and rnd_ready=0, one word/cycle otherwise.
// Ports: clk, reset (async active-low), seed/seed_load (reseed, highest priority),
//        rnd/rnd_valid/rnd_ready (output stream, channel i at [i*OUT_W +: OUT_W]), busy (warm-up running).
module rng_bank
  import rng_pkg::*;
#(
  parameter int          NUM_CH       = 2,
  parameter int          OUT_W        = 16,
  parameter int          LEAP         = 1,
  parameter int          WARMUP_CYC   = 16,
  parameter logic [31:0] DEFAULT_SEED = 32'h0000_0001
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [31:0]             seed,
  input  logic                    seed_load,
  output logic [NUM_CH*OUT_W-1:0] rnd,
  output logic                    rnd_valid,
  input  logic                    rnd_ready,
  output logic                    busy
);

  localparam fsm_e        FSM_INIT = (WARMUP_CYC == 0) ? LOAD : WARMUP;
  localparam logic [15:0] CNT_INIT = 16'(WARMUP_CYC);

  fsm_e                    fsm_q, fsm_d;
  logic [15:0]             cnt_q, cnt_d;
  logic [NUM_CH*OUT_W-1:0] rnd_q, rnd_d;
  logic                    vld_q, vld_d;
  logic                    ld;
  logic                    adv;

  logic [LFSR_W-1:0]       ch_state [NUM_CH];
  logic [NUM_CH*OUT_W-1:0] ext_all;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam logic [LFSR_W-1:0] CH_SALT = salt(i);

    logic [LFSR_W-1:0] ch_seed;
    logic              unused_mid;

    assign ch_seed = guard(seed ^ CH_SALT);

    lfsr_leap_core #(
      .LEAP      (LEAP),
      .RESET_VAL (guard(DEFAULT_SEED ^ CH_SALT))
    ) u_core (
      .clk      (clk),
      .reset    (reset),
      .load     (ld),
      .load_val (ch_seed),
      .adv      (adv),
      .state    (ch_state[i])
    );

    // Top OUT_W-5 bits plus the five LSBs; the middle of the state is not exported.
    assign ext_all[i*OUT_W +: OUT_W] = {ch_state[i][LFSR_W-1 -: OUT_W-5], ch_state[i][4:0]};
    assign unused_mid = ^ch_state[i];
  end

  always_comb begin
    fsm_d = fsm_q;
    cnt_d = cnt_q;
    rnd_d = rnd_q;
    vld_d = vld_q;
    ld    = 1'b0;
    adv   = 1'b0;
    if (seed_load) begin
      // Reseed wins over everything; a same-cycle handshake still completes
      // because the consumer sampled rnd on this edge.
      ld    = 1'b1;
      cnt_d = CNT_INIT;
      vld_d = 1'b0;
      fsm_d = FSM_INIT;
    end else begin
      case (fsm_q)
        WARMUP: begin
          adv   = 1'b1;
          cnt_d = cnt_q - 16'd1;
          if (cnt_q <= 16'd1) begin
            fsm_d = LOAD;
          end
        end
        LOAD: begin
          rnd_d = ext_all;
          adv   = 1'b1;
          vld_d = 1'b1;
          fsm_d = RUN;
        end
        RUN: begin
          if (vld_q && rnd_ready) begin
            rnd_d = ext_all;
            adv   = 1'b1;
          end
        end
        default: begin
          fsm_d = FSM_INIT;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm_q <= FSM_INIT;
      cnt_q <= CNT_INIT;
      rnd_q <= '0;
      vld_q <= 1'b0;
    end else begin
      fsm_q <= fsm_d;
      cnt_q <= cnt_d;
      rnd_q <= rnd_d;
      vld_q <= vld_d;
    end
  end

  assign rnd       = rnd_q;
  assign rnd_valid = vld_q;
  assign busy      = (fsm_q == WARMUP);

endmodule

// File: tb/tb_rng_bank.sv
// tb_rng_bank: directed bench for rng_bank with a scoreboard fed by a bench-side LFSR model.
// Instance 0: 2ch/16b/leap1/warm-up 16; instance 1: 2ch/16b/leap1/no warm-up; instance 2: 5ch/32b/leap32/no warm-up.
// Outputs sampled on the falling edge; inputs driven on the falling edge.
module tb_rng_bank;

  logic         clk       = 1'b0;
  logic         reset     = 1'b0;
  logic [31:0]  seed      = '0;
  logic [2:0]   seed_load = '0;
  logic [2:0]   ready     = '0;
  logic [2:0]   vld;
  logic [2:0]   busy;
  logic [31:0]  rnd0;
  logic [31:0]  rnd1;
  logic [159:0] rnd2;

  int errors = 0;
  int checks = 0;
  int xfer_a = 0;

  always #5 clk = ~clk;

  rng_bank #(.NUM_CH(2), .OUT_W(16), .LEAP(1), .WARMUP_CYC(16)) u_a (
    .clk(clk), .reset(reset), .seed(seed), .seed_load(seed_load[0]),
    .rnd(rnd0), .rnd_valid(vld[0]), .rnd_ready(ready[0]), .busy(busy[0]));

  rng_bank #(.NUM_CH(2), .OUT_W(16), .LEAP(1), .WARMUP_CYC(0)) u_z (
    .clk(clk), .reset(reset), .seed(seed), .seed_load(seed_load[1]),
    .rnd(rnd1), .rnd_valid(vld[1]), .rnd_ready(ready[1]), .busy(busy[1]));

  rng_bank #(.NUM_CH(5), .OUT_W(32), .LEAP(32), .WARMUP_CYC(0)) u_b (
    .clk(clk), .reset(reset), .seed(seed), .seed_load(seed_load[2]),
    .rnd(rnd2), .rnd_valid(vld[2]), .rnd_ready(ready[2]), .busy(busy[2]));

  always @(posedge clk) begin
    if (vld[0] && ready[0]) xfer_a <= xfer_a + 1;
  end

  // ---------------- reference model ----------------
  logic [31:0]  ms [3][5];
  logic [159:0] q0[$];
  logic [159:0] q1[$];
  logic [159:0] q2[$];

  function automatic int nch(input int id); return (id == 2) ? 5 : 2; endfunction
  function automatic int ow(input int id);  return (id == 2) ? 32 : 16; endfunction
  function automatic int lp(input int id);  return (id == 2) ? 32 : 1; endfunction
  function automatic int wu(input int id);  return (id == 0) ? 16 : 0; endfunction

  function automatic logic [31:0] m_shift(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  function automatic logic [31:0] m_salt(input int i);
    logic [31:0] r;
    r = (i % 2 == 1) ? 32'hFFFF_FFFF : 32'h0;
    r = r ^ ((i / 2) * 32'h9E37_79B9);
    return r;
  endfunction

  function automatic logic [31:0] m_ext(input logic [31:0] s, input int w);
    if (w == 32) return s;
    return ((s >> (32 - (w - 5))) << 5) | (s & 32'h1F);
  endfunction

  function automatic logic [159:0] get_rnd(input int id);
    if (id == 0) return 160'(rnd0);
    if (id == 1) return 160'(rnd1);
    return rnd2;
  endfunction

  task automatic reseed_model(input int id, input logic [31:0] sd);
    for (int c = 0; c < nch(id); c++) begin
      logic [31:0] s;
      s = sd ^ m_salt(c);
      if (s == 32'h0) s = 32'h1;
      for (int k = 0; k < lp(id) * wu(id); k++) s = m_shift(s);
      ms[id][c] = s;
    end
  endtask

  task automatic push(input int id, input int n);
    for (int k = 0; k < n; k++) begin
      logic [159:0] v;
      v = '0;
      for (int c = 0; c < nch(id); c++) begin
        v = v | (160'(m_ext(ms[id][c], ow(id))) << (c * ow(id)));
        for (int j = 0; j < lp(id); j++) ms[id][c] = m_shift(ms[id][c]);
      end
      case (id)
        0:       q0.push_back(v);
        1:       q1.push_back(v);
        default: q2.push_back(v);
      endcase
    end
  endtask

  task automatic clear(input int id);
    case (id)
      0:       q0.delete();
      1:       q1.delete();
      default: q2.delete();
    endcase
  endtask

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s observed=%0h required=%0h", tag, obs, req);
    end
  endtask

  // Compare the presented word against the scoreboard, then accept it on the next edge.
  task automatic consume(input int id, input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      logic [159:0] e;
      bit           ok;
      ok = 1'b1;
      e  = '0;
      case (id)
        0:       if (q0.size() > 0) e = q0.pop_front(); else ok = 1'b0;
        1:       if (q1.size() > 0) e = q1.pop_front(); else ok = 1'b0;
        default: if (q2.size() > 0) e = q2.pop_front(); else ok = 1'b0;
      endcase
      if (!ok) begin
        checks++;
        errors++;
        $display("FAIL %s scoreboard empty", tag);
      end else begin
        check({tag, "_vld"}, 160'(vld[id]), 160'(1'b1));
        check(tag, get_rnd(id), e);
      end
      ready[id] = 1'b1;
      @(negedge clk);
    end
    ready[id] = 1'b0;
  endtask

  // Count edges until rnd_valid, bounded so a stuck DUT still reaches the summary.
  task automatic wait_vld(input int id, input int start, input int req, input string tag);
    int n;
    n = start;
    while (!vld[id] && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(tag, 160'(n), 160'(req));
  endtask

  initial begin
    repeat (2) @(negedge clk);

    // reset values
    check("rst_rnd_a",  160'(rnd0),    160'(0));
    check("rst_vld_a",  160'(vld[0]),  160'(0));
    check("rst_busy_a", 160'(busy[0]), 160'(1));
    check("rst_busy_z", 160'(busy[1]), 160'(0));
    check("rst_vld_b",  160'(vld[2]),  160'(0));
    check("rst_rnd_b",  rnd2,          160'(0));

    reseed_model(0, 32'h1);
    reseed_model(1, 32'h1);
    reseed_model(2, 32'h1);

    // warm-up timing: busy for 16 cycles, valid on edge 17
    reset = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      check("warm_busy", 160'(busy[0]), 160'(k < 16));
      check("warm_vld",  160'(vld[0]),  160'(k == 17));
    end
    push(0, 4);
    consume(0, 4, "a_stream");

    // backpressure: 10 stalled cycles, then resume
    push(0, 4);
    for (int k = 0; k < 10; k++) begin
      check("bp_hold_rnd", 160'(rnd0),   (q0.size() > 0) ? q0[0] : '0);
      check("bp_hold_vld", 160'(vld[0]), 160'(1));
      @(negedge clk);
    end
    consume(0, 4, "bp_resume");

    // default sequence from seed 0 with no warm-up
    seed         = 32'h0;
    seed_load[1] = 1'b1;
    @(negedge clk);
    seed_load[1] = 1'b0;
    check("z_reseed_vld", 160'(vld[1]), 160'(0));
    reseed_model(1, 32'h0);
    clear(1);
    push(1, 3);
    wait_vld(1, 1, 2, "z_lat");
    check("z_first", 160'(rnd1), 160'(32'hFFFF_0001));
    consume(1, 1, "z_seq");
    check("z_second_ch0", 160'(rnd1[15:0]), 160'(16'h8023));
    consume(1, 2, "z_seq");

    // reseed colliding with a handshake
    push(0, 1);
    consume(0, 0, "a_none");
    check("coll_word", 160'(rnd0), (q0.size() > 0) ? q0[0] : '0);
    clear(0);
    ready[0]     = 1'b1;
    seed         = 32'hDEAD_BEEF;
    seed_load[0] = 1'b1;
    @(negedge clk);
    seed_load[0] = 1'b0;
    ready[0]     = 1'b0;
    check("coll_xfer",  160'(xfer_a),  160'(9));
    check("coll_vld",   160'(vld[0]),  160'(0));
    check("coll_busy",  160'(busy[0]), 160'(1));
    reseed_model(0, 32'hDEAD_BEEF);
    push(0, 3);
    wait_vld(0, 1, 18, "a_reseed_lat");
    consume(0, 3, "a_reseed");

    // leap/channel sweep: default stream, then seed 0 to expose the raw salts
    push(2, 3);
    consume(2, 3, "b_default");
    seed         = 32'h0;
    seed_load[2] = 1'b1;
    @(negedge clk);
    seed_load[2] = 1'b0;
    reseed_model(2, 32'h0);
    clear(2);
    push(2, 3);
    wait_vld(2, 1, 2, "b_lat");
    check("b_salt", rnd2, {32'h3C6E_F372, 32'h61C8_8646, 32'h9E37_79B9, 32'hFFFF_FFFF, 32'h0000_0001});
    consume(2, 3, "b_seed0");

    // asynchronous reset mid-stream
    ready[0] = 1'b1;
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    ready[0] = 1'b0;
    check("arst_rnd_a",  160'(rnd0),    160'(0));
    check("arst_vld_a",  160'(vld[0]),  160'(0));
    check("arst_busy_a", 160'(busy[0]), 160'(1));
    check("arst_rnd_z",  160'(rnd1),    160'(0));
    @(negedge clk);
    reset = 1'b1;
    reseed_model(0, 32'h1);
    clear(0);
    push(0, 4);
    wait_vld(0, 0, 17, "a_rst_lat");
    consume(0, 4, "a_post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rng_bank.md
# rng_bank

Parametrised multi-channel random-number source and the successor to the fixed dual-channel 16-bit generator. It runs NUM_CH independent 32-bit Galois LFSRs, each seeded from one shared seed with a per-channel salt. It discards a configurable warm-up run after every (re)seed, then presents one OUT_W-bit word per channel through a valid/ready handshake with a configurable leap of LFSR shifts per word. Consumers are the stochastic datapath blocks that previously took `rnd1`/`rnd2` directly.

## Interface
- NUM_CH, default 2: number of channels, 1..16.
- OUT_W, default 16: output bits per channel, 6..32.
- LEAP, default 1: LFSR shifts per advance, 1..32.
- WARMUP_CYC, default 16: discarded advances after reset or reseed, 0..65535.
- DEFAULT_SEED, default 32'h0000_0001: seed used out of reset.
- clk, input, 1: sole clock; all state on rising edge.
- reset, input, 1: asynchronous, active-low; asserting it clears state immediately; release is synchronous to clk.
- seed, input, 32: seed value, sampled only when seed_load=1.
- seed_load, input, 1: one-cycle reseed request.
- rnd, output, NUM_CH*OUT_W: channel i occupies bits [i*OUT_W +: OUT_W].
- rnd_valid, output, 1: rnd holds an unconsumed word.
- rnd_ready, input, 1: consumer accepts rnd this cycle.
- busy, output, 1: warm-up in progress.

## Operation
- Channel seed: s_i = seed ^ salt(i), where salt(i) = (i odd ? 32'hFFFF_FFFF : 0) ^ ((i>>1) * 32'h9E37_79B9). Channels 0 and 1 therefore receive seed and ~seed.
- Zero guard: if s_i == 0, load 32'h0000_0001 instead.
- Single shift: next = (s >> 1) ^ (s[0] ? 32'h8020_0003 : 0). This is the polynomial x^32+x^22+x^2+x+1.
- Advance: LEAP single shifts, unrolled combinationally, applied in one cycle.
- Extract: word = {s[31 -: OUT_W-5], s[4:0]}. For OUT_W=32 this is the whole state.
- FSM states:
  - WARMUP: advance every cycle and decrement the counter. When the counter is 0, go to LOAD. If WARMUP_CYC=0, WARMUP is skipped.
  - LOAD: rnd <= extract(state), advance state, rnd_valid <= 1, go to RUN.
  - RUN: on rnd_valid & rnd_ready, rnd <= extract(state) and advance state. Otherwise rnd and state hold.
- seed_load, in any state: next cycle all states = guarded s_i, counter = WARMUP_CYC, rnd_valid = 0, FSM = WARMUP (or LOAD if WARMUP_CYC=0).
- seed_load has priority over every other event. A handshake in the same cycle still counts as a completed transfer.
- busy = 1 exactly while the FSM is in WARMUP.

## Timing
- Reset values:
  - rnd = 0, rnd_valid = 0, busy = 1 (0 if WARMUP_CYC=0).
  - States = guarded DEFAULT_SEED ^ salt(i).
  - FSM = WARMUP, counter = WARMUP_CYC.
- First rnd_valid is seen after WARMUP_CYC+1 rising edges following reset release. Reseed latency is the same, counted from the edge that samples seed_load.
- Throughput: one word per cycle while rnd_ready is held high; no bubbles in RUN.
- While rnd_valid=1 and rnd_ready=0, rnd is stable.
- rnd_ready is ignored while rnd_valid=0.
- Reset asserted mid-warm-up or mid-stream: outputs go to reset values asynchronously and the pending word is lost.

## Structure
- Package rng_pkg holds:
  - LFSR_W = 32 and TAP_MASK = 32'h8020_0003.
  - Function salt(i) and function guard(s).
  - FSM enum {WARMUP, LOAD, RUN}.
- Sub-module lfsr_leap_core, instantiated NUM_CH times:
  - Holds one 32-bit state with load and advance controls.
  - Parameter LEAP.
  - Output is the current state; rng_bank does the extraction.
- Top level holds the FSM, warm-up counter, output register and salt generation.

## Test plan
- Default-sequence check. Setup: NUM_CH=2, OUT_W=16, LEAP=1, WARMUP_CYC=0, seed_load with seed=0, rnd_ready=1. Required response:
  - Channel 0 gives 16'h0001, then 16'h8023 (state 1, then 32'h8020_0003).
  - Channel 1 gives 16'hFFFF on the first word.
- Warm-up timing: WARMUP_CYC=16. busy is high for exactly 16 cycles, and rnd_valid rises on edge 17 after reset release.
- Backpressure: hold rnd_ready=0 for 10 cycles in RUN. rnd is unchanged and rnd_valid stays 1. Resuming matches the next word of the no-stall reference model.
- Reseed collision: seed_load and a handshake in the same cycle. The transfer is counted, rnd_valid=0 on the next cycle, and the stream restarts from the new seed after warm-up.
- Leap and channel sweep: NUM_CH=5, LEAP=32, OUT_W=32. Every word equals the reference model's state after 32 shifts, and channel 4 uses salt 32'h3C6E_F372.
- Async reset mid-stream: assert reset between clock edges. Outputs clear immediately, and the sequence after release repeats the post-reset sequence exactly.
